// File: rtl/window_feeder.sv
// Window feeder: collects a raster stream of 8-bit pixels into a 7x7 window of
// IEEE-754 singles and presents all seven rows at once with a timed de strobe.
module window_feeder #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   pix_in,
   input  logic         pix_valid,
   input  logic         pix_sow,
   output logic         pix_ready,
   output logic         de_out,
   output logic [223:0] line_0_out,
   output logic [223:0] line_1_out,
   output logic [223:0] line_2_out,
   output logic [223:0] line_3_out,
   output logic [223:0] line_4_out,
   output logic [223:0] line_5_out,
   output logic [223:0] line_6_out,
   output logic [15:0]  win_count,
   output logic         resync_err
);

   localparam logic [1:0] ST_COLLECT = 2'd0;
   localparam logic [1:0] ST_LOAD    = 2'd1;
   localparam logic [1:0] ST_HOLD    = 2'd2;

   localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

   logic [1:0]   state_reg;
   logic [2:0]   row_reg;
   logic [2:0]   col_reg;
   logic [7:0]   hold_reg;
   logic         ready_reg;
   logic         de_reg;
   logic [15:0]  win_count_reg;
   logic         resync_reg;

   logic         accept;
   logic         last_pix;
   logic [2:0]   dest_row;
   logic [2:0]   dest_col;
   logic [31:0]  pix_float;
   logic [31:0]  shadow_reg [7][7];
   logic [223:0] line_bus [7];

   // Exact unsigned-to-float: the MSB becomes the implicit one, the rest the mantissa.
   function automatic logic [31:0] to_float(input logic [7:0] v);
      logic [2:0] p;
      logic [7:0] norm;
      p = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) p = 3'(i);
      end
      norm = v << (3'd7 - p);
      if (v == 8'd0) return 32'd0;
      return {1'b0, 8'd127 + {5'd0, p}, norm[6:0], 16'd0};
   endfunction

   always_comb begin
      accept    = pix_valid && ready_reg;
      dest_row  = pix_sow ? 3'd0 : row_reg;
      dest_col  = pix_sow ? 3'd0 : col_reg;
      last_pix  = accept && (dest_row == 3'd6) && (dest_col == 3'd6);
      pix_float = to_float(pix_in);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_COLLECT;
         row_reg       <= 3'd0;
         col_reg       <= 3'd0;
         hold_reg      <= 8'd0;
         ready_reg     <= 1'b0;
         de_reg        <= 1'b0;
         win_count_reg <= 16'd0;
         resync_reg    <= 1'b0;
      end else begin
         resync_reg <= accept && pix_sow && ((row_reg != 3'd0) || (col_reg != 3'd0));

         // Position tracking runs in any state; completion wraps it back to (0,0).
         if (accept) begin
            if (pix_sow) begin
               row_reg <= 3'd0;
               col_reg <= 3'd1;
            end else if (col_reg == 3'd6) begin
               col_reg <= 3'd0;
               row_reg <= (row_reg == 3'd6) ? 3'd0 : row_reg + 3'd1;
            end else begin
               col_reg <= col_reg + 3'd1;
            end
         end

         case (state_reg)
            ST_COLLECT: begin
               ready_reg <= !last_pix;
               if (last_pix) state_reg <= ST_LOAD;
            end
            ST_LOAD: begin
               de_reg        <= 1'b1;
               win_count_reg <= win_count_reg + 16'd1;
               hold_reg      <= HOLD_INIT;
               ready_reg     <= (HOLD_INIT == 8'd0);
               state_reg     <= ST_HOLD;
            end
            ST_HOLD: begin
               // Ready reopens one cycle before de drops so the next accept
               // lands exactly HOLD_CYCLES cycles after the emission edge.
               if (hold_reg == 8'd0) begin
                  de_reg    <= 1'b0;
                  ready_reg <= 1'b1;
                  state_reg <= ST_COLLECT;
               end else begin
                  hold_reg  <= hold_reg - 8'd1;
                  ready_reg <= (hold_reg == 8'd1);
               end
            end
            default: begin
               state_reg <= ST_COLLECT;
               ready_reg <= 1'b0;
               de_reg    <= 1'b0;
            end
         endcase
      end
   end

   for (genvar gi = 0; gi < 7; gi++) begin : g_row
      logic [223:0] line_reg;

      for (genvar gj = 0; gj < 7; gj++) begin : g_col
         always_ff @(posedge clk) begin
            if (accept && (dest_row == 3'(gi)) && (dest_col == 3'(gj)))
               shadow_reg[gi][gj] <= pix_float;
         end
      end

      always_ff @(posedge clk) begin
         if (reset)
            line_reg <= '0;
         else if (state_reg == ST_LOAD)
            line_reg <= {shadow_reg[gi][0], shadow_reg[gi][1], shadow_reg[gi][2],
                         shadow_reg[gi][3], shadow_reg[gi][4], shadow_reg[gi][5],
                         shadow_reg[gi][6]};
      end

      assign line_bus[gi] = line_reg;
   end

   assign pix_ready  = ready_reg;
   assign de_out     = de_reg;
   assign win_count  = win_count_reg;
   assign resync_err = resync_reg;
   assign line_0_out = line_bus[0];
   assign line_1_out = line_bus[1];
   assign line_2_out = line_bus[2];
   assign line_3_out = line_bus[3];
   assign line_4_out = line_bus[4];
   assign line_5_out = line_bus[5];
   assign line_6_out = line_bus[6];

endmodule

// File: tb/tb_window_feeder.sv
// Directed bench for window_feeder: vector table for conversions plus
// hand-written sequences for hold, gaps, resync and reset-in-hold.
module tb_window_feeder;
   localparam int HOLD = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [7:0]   pix_in = 8'd0;
   logic         pix_valid = 1'b0;
   logic         pix_sow = 1'b0;
   logic         pix_ready;
   logic         de_out;
   logic [223:0] line_0_out, line_1_out, line_2_out, line_3_out;
   logic [223:0] line_4_out, line_5_out, line_6_out;
   logic [15:0]  win_count;
   logic         resync_err;

   window_feeder #(.HOLD_CYCLES(HOLD)) dut (
      .clk        (clk),
      .reset      (reset),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .pix_sow    (pix_sow),
      .pix_ready  (pix_ready),
      .de_out     (de_out),
      .line_0_out (line_0_out),
      .line_1_out (line_1_out),
      .line_2_out (line_2_out),
      .line_3_out (line_3_out),
      .line_4_out (line_4_out),
      .line_5_out (line_5_out),
      .line_6_out (line_6_out),
      .win_count  (win_count),
      .resync_err (resync_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  pix;
      logic [31:0] flt;
   } conv_vec_t;

   conv_vec_t    conv_tab [5];
   logic [7:0]   win_vals [49];
   logic [223:0] prev_lines [7];
   int           n_cmp = 0;
   int           n_err = 0;

   // Independent reference: narrow the exact double representation to single.
   function automatic logic [31:0] ref_float(input int v);
      logic [63:0] d;
      if (v == 0) return 32'd0;
      d = $realtobits(real'(v));
      return {1'b0, 8'(d[62:52] - 11'd896), d[51:29]};
   endfunction

   function automatic logic [223:0] model_line(input int r);
      logic [223:0] l;
      l = '0;
      for (int c = 0; c < 7; c++)
         l[223 - 32*c -: 32] = ref_float(int'(win_vals[7*r + c]));
      return l;
   endfunction

   function automatic logic [223:0] dut_line(input int r);
      case (r)
         0:       return line_0_out;
         1:       return line_1_out;
         2:       return line_2_out;
         3:       return line_3_out;
         4:       return line_4_out;
         5:       return line_5_out;
         default: return line_6_out;
      endcase
   endfunction

   task automatic check(input string name, input logic [223:0] act, input logic [223:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic send_pix(input logic [7:0] p, input logic s);
      int waits;
      waits = 0;
      pix_in = p;
      pix_sow = s;
      pix_valid = 1'b1;
      while (!pix_ready && waits < 100) begin
         @(negedge clk);
         waits++;
      end
      if (!pix_ready) check("ready_timeout", pix_ready, 1'b1);
      @(negedge clk);
      pix_valid = 1'b0;
      pix_sow = 1'b0;
   endtask

   task automatic send_range(input int first, input int count, input bit gaps);
      for (int i = first; i < first + count; i++) begin
         if (gaps) repeat ((i * 7 + 3) % 3) @(negedge clk);
         send_pix(win_vals[i], i == 0);
      end
   endtask

   task automatic expect_emission(input string tag, input int win_no);
      int hi;
      check({tag, "_de_pre"}, de_out, 1'b0);
      @(negedge clk);
      check({tag, "_de_rise"}, de_out, 1'b1);
      hi = 1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (de_out) hi++;
         else break;
      end
      check({tag, "_de_len"}, hi, HOLD);
      check({tag, "_ready_after"}, pix_ready, 1'b1);
      for (int r = 0; r < 7; r++)
         check($sformatf("%s_line%0d", tag, r), dut_line(r), model_line(r));
      check({tag, "_win_count"}, win_count, 16'(win_no));
      $display("window %0d (%s): de high %0d cycles, win_count=%0d", win_no, tag, hi, win_count);
   endtask

   initial begin
      int low;
      conv_tab[0] = '{8'd255, 32'h437F0000};
      conv_tab[1] = '{8'd128, 32'h43000000};
      conv_tab[2] = '{8'd1,   32'h3F800000};
      conv_tab[3] = '{8'd0,   32'h00000000};
      conv_tab[4] = '{8'd129, 32'h43010000};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ready", pix_ready, 1'b0);
      check("rst_de", de_out, 1'b0);
      check("rst_win_count", win_count, 16'd0);
      check("rst_resync", resync_err, 1'b0);
      check("rst_line0", line_0_out, '0);
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", pix_ready, 1'b1);

      // Ramp 0..48 with sow on the first pixel
      for (int i = 0; i < 49; i++) win_vals[i] = 8'(i);
      send_range(0, 1, 1'b0);
      check("sow_at_origin_no_err", resync_err, 1'b0);
      send_range(1, 48, 1'b0);
      expect_emission("ramp", 1);
      check("ramp_line0_literal", line_0_out,
            224'h00000000_3F800000_40000000_40400000_40800000_40A00000_40C00000);

      // pix_valid held high through the hold period
      for (int i = 0; i < 49; i++) win_vals[i] = 8'((i * 37 + 11) % 256);
      send_range(0, 48, 1'b0);
      pix_in = win_vals[48];
      pix_sow = 1'b0;
      pix_valid = 1'b1;
      @(negedge clk);
      pix_in = 8'd77;
      low = 0;
      for (int k = 0; k < 20 && !pix_ready; k++) begin
         low++;
         @(negedge clk);
      end
      check("hold_ready_low_cycles", low, HOLD);
      check("hold_de_still_high", de_out, 1'b1);
      check("hold_win_count", win_count, 16'd2);
      for (int r = 0; r < 7; r++) begin
         prev_lines[r] = model_line(r);
         check($sformatf("hold_line%0d", r), dut_line(r), prev_lines[r]);
      end
      @(negedge clk);
      pix_valid = 1'b0;
      check("hold_de_dropped", de_out, 1'b0);
      win_vals[0] = 8'd77;
      for (int i = 1; i < 49; i++) win_vals[i] = 8'(i * 3 + 5);
      send_range(1, 47, 1'b0);
      for (int r = 0; r < 7; r++)
         check($sformatf("stable_line%0d", r), dut_line(r), prev_lines[r]);
      send_range(48, 1, 1'b0);
      expect_emission("after_hold", 3);

      // Ramp again with gaps between pixels
      for (int i = 0; i < 49; i++) win_vals[i] = 8'(i);
      send_range(0, 49, 1'b1);
      expect_emission("gaps", 4);

      // Conversion vectors at slot [3][3]
      for (int t = 0; t < 5; t++) begin
         for (int i = 0; i < 49; i++) win_vals[i] = 8'd0;
         win_vals[24] = conv_tab[t].pix;
         send_range(0, 49, 1'b0);
         expect_emission($sformatf("conv%0d", t), 5 + t);
         check($sformatf("conv%0d_value", t), line_3_out[127:96], conv_tab[t].flt);
      end

      // Resync after a 20-pixel partial window
      for (int i = 0; i < 20; i++) win_vals[i] = 8'(i + 1);
      send_range(0, 20, 1'b0);
      check("resync_quiet", resync_err, 1'b0);
      send_pix(8'd200, 1'b1);
      check("resync_pulse", resync_err, 1'b1);
      @(negedge clk);
      check("resync_clear", resync_err, 1'b0);
      win_vals[0] = 8'd200;
      for (int i = 1; i < 49; i++) win_vals[i] = 8'(i);
      send_range(1, 48, 1'b0);
      expect_emission("resync", 10);
      check("resync_origin", line_0_out[223:192], 32'h43480000);

      // Reset during the second hold cycle
      for (int i = 0; i < 49; i++) win_vals[i] = 8'(255 - i);
      send_range(0, 49, 1'b0);
      @(negedge clk);
      check("rh_de_hold1", de_out, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rh_de", de_out, 1'b0);
      check("rh_win_count", win_count, 16'd0);
      check("rh_ready", pix_ready, 1'b0);
      for (int r = 0; r < 7; r++)
         check($sformatf("rh_line%0d", r), dut_line(r), '0);
      reset = 1'b0;
      @(negedge clk);
      check("rh_ready_after", pix_ready, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
